instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the opcode decoder/control unit.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency.
- Presents each fetched instruction, its PC, PC+4 and its opcode field to decode with a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution.

---
 rtl/mips_pkg.sv | 14 +
 rtl/pc_register.sv | 25 ++
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch front end: state encoding, reset PC and opcode field position.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam int          OPCODE_MSB   = 31;
  localparam int          OPCODE_LSB   = 26;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// Enable register with async active-low reset and a parameterised reset value.
module pc_register #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= RESET_VAL;
    end else if (en_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and hands words to decode.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [5:0]            opcode_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  misalign_o,
  output logic [31:0]           inst_count_o
);

  fetch_state_e          state_q, state_d;
  logic                  squash_q, squash_d;
  logic                  valid_q, valid_d;
  logic                  misalign_q, misalign_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  fetch_en, pc_en;
  logic [DATA_WIDTH-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    squash_d   = squash_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    count_d    = count_q;
    misalign_d = misalign_q | (redirect_i & (|redirect_pc_i[1:0]));
    fetch_en   = 1'b0;
    fetch_pc_d = fetch_pc_q;
    pc_en      = 1'b0;

    if (redirect_i) begin
      fetch_en   = 1'b1;
      fetch_pc_d = redirect_tgt;
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack_i) begin
          if (squash_q) begin
            squash_d = 1'b0;
          end else if (!redirect_i) begin
            inst_d     = imem_rdata_i;
            pc_en      = 1'b1;
            fetch_en   = 1'b1;
            fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
            valid_d    = 1'b1;
            state_d    = S_HOLD;
          end
        end else if (redirect_i) begin
          // The outstanding request cannot be withdrawn; drop its data when it lands.
          squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (inst_ready_i) begin
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          state_d = S_FETCH;
        end else if (redirect_i) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address is frozen while a request is outstanding, otherwise it tracks the next fetch PC.
    addr_d = (state_q == S_FETCH && !imem_ack_i) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      squash_q   <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      inst_q     <= '0;
      addr_q     <= RESET_PC;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      squash_q   <= squash_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      inst_q     <= inst_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
    end
  end

  pc_register #(.DATA_WIDTH(DATA_WIDTH), .RESET_VAL(RESET_PC)) u_fetch_pc (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (fetch_en),
    .d_i   (fetch_pc_d),
    .q_o   (fetch_pc_q)
  );

  pc_register #(.DATA_WIDTH(DATA_WIDTH), .RESET_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (pc_en),
    .d_i   (fetch_pc_q),
    .q_o   (pc_q)
  );

  assign imem_req_o   = (state_q == S_FETCH);
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign opcode_o     = inst_q[OPCODE_MSB:OPCODE_LSB];
  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_q + DATA_WIDTH'(4);
  assign misalign_o   = misalign_q;
  assign inst_count_o = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected fetched words.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [5:0]  opcode_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        misalign_o;
  logic [31:0] inst_count_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_count = '0;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .opcode_o      (opcode_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .misalign_o    (misalign_o),
    .inst_count_o  (inst_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req(input logic [31:0] exp_addr);
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", 32'(imem_req_o), 32'd1);
    chk("req_addr", imem_addr_o, exp_addr);
  endtask

  // Memory model: req held for lat cycles, ack on the last one, data = addr ^ A5A5_0000.
  task automatic mem_respond(input int lat);
    logic [31:0] a;
    exp_t        e;
    a = imem_addr_o;
    for (int k = 1; k < lat; k++) begin
      step();
      chk("req_stable", 32'(imem_req_o), 32'd1);
      chk("addr_stable", imem_addr_o, a);
      chk("no_valid_wait", 32'(inst_valid_o), 32'd0);
    end
    imem_ack_i   = 1'b1;
    imem_rdata_i = a ^ 32'hA5A5_0000;
    e.pc   = a;
    e.inst = a ^ 32'hA5A5_0000;
    sb.push_back(e);
    step();
    imem_ack_i   = 1'b0;
    imem_rdata_i = '0;
  endtask

  task automatic check_head(output exp_t e, output bit ok);
    chk("valid", 32'(inst_valid_o), 32'd1);
    chk("sb_nonempty", (sb.size() == 0) ? 32'd0 : 32'd1, 32'd1);
    ok = (sb.size() != 0);
    e  = '0;
    if (ok) begin
      e = sb.pop_front();
      chk("inst", inst_o, e.inst);
      chk("pc", pc_o, e.pc);
      chk("pc_plus4", pc_plus4_o, e.pc + 32'd4);
      chk("opcode", 32'(opcode_o), {26'b0, e.inst[31:26]});
      $display("[TB] fetched pc=%h inst=%h", e.pc, e.inst);
    end
  endtask

  task automatic consume(input int stall);
    exp_t e;
    bit   ok;
    check_head(e, ok);
    for (int k = 0; k < stall; k++) begin
      step();
      chk("hold_valid", 32'(inst_valid_o), 32'd1);
      chk("hold_inst", inst_o, e.inst);
      chk("hold_pc", pc_o, e.pc);
      chk("hold_no_req", 32'(imem_req_o), 32'd0);
    end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    exp_count++;
    chk("count", inst_count_o, exp_count);
    chk("valid_after_take", 32'(inst_valid_o), 32'd0);
  endtask

  initial begin
    exp_t e;
    bit   ok;

    repeat (2) step();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0040_0000);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_pc", pc_o, 32'h0040_0000);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_count", inst_count_o, 32'd0);
    reset = 1'b1;

    // Sequential stream, decode always ready.
    for (int i = 0; i < 3; i++) begin
      wait_req(32'h0040_0000 + 32'(4 * i));
      mem_respond(2);
      consume(0);
    end
    chk("count_three", inst_count_o, 32'd3);

    // Slow memory and a stalled decoder.
    wait_req(32'h0040_000C);
    mem_respond(3);
    consume(4);

    // Redirect during an outstanding request: the returning word is squashed.
    wait_req(32'h0040_0010);
    step();
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0100;
    step();
    redirect_i = 1'b0;
    chk("sq_req_held", 32'(imem_req_o), 32'd1);
    chk("sq_addr_held", imem_addr_o, 32'h0040_0010);
    step();
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    step();
    imem_ack_i = 1'b0;
    chk("sq_no_valid", 32'(inst_valid_o), 32'd0);
    chk("sq_req_next", 32'(imem_req_o), 32'd1);
    chk("sq_addr_next", imem_addr_o, 32'h0040_0100);
    mem_respond(2);
    consume(0);

    // Redirect together with a consume in HOLD.
    wait_req(32'h0040_0104);
    mem_respond(1);
    check_head(e, ok);
    inst_ready_i  = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0200;
    step();
    inst_ready_i = 1'b0;
    redirect_i   = 1'b0;
    exp_count++;
    chk("rdc_count", inst_count_o, exp_count);
    chk("rdc_valid", 32'(inst_valid_o), 32'd0);
    chk("rdc_addr", imem_addr_o, 32'h0040_0200);

    // Misaligned redirect in HOLD without consume: instruction dropped.
    chk("pre_misalign", 32'(misalign_o), 32'd0);
    wait_req(32'h0040_0200);
    mem_respond(2);
    check_head(e, ok);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0103;
    step();
    redirect_i = 1'b0;
    chk("mis_drop_valid", 32'(inst_valid_o), 32'd0);
    chk("mis_flag", 32'(misalign_o), 32'd1);
    chk("mis_addr", imem_addr_o, 32'h0040_0100);
    chk("mis_count", inst_count_o, exp_count);
    mem_respond(2);
    consume(1);
    chk("mis_sticky", 32'(misalign_o), 32'd1);

    // PC wrap at the top of the address space.
    wait_req(32'h0040_0104);
    mem_respond(1);
    check_head(e, ok);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    wait_req(32'hFFFF_FFFC);
    mem_respond(2);
    chk("wrap_pc_plus4", pc_plus4_o, 32'd0);
    consume(0);
    wait_req(32'h0000_0000);

    // Reset while a request is pending, then a late ack in IDLE.
    step();
    reset = 1'b0;
    #1;
    chk("mr_req", 32'(imem_req_o), 32'd0);
    chk("mr_valid", 32'(inst_valid_o), 32'd0);
    chk("mr_addr", imem_addr_o, 32'h0040_0000);
    chk("mr_misalign", 32'(misalign_o), 32'd0);
    chk("mr_count", inst_count_o, 32'd0);
    exp_count = '0;
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'h1234_5678;
    step();
    chk("mr_ack_ignored", 32'(inst_valid_o), 32'd0);
    reset = 1'b1;
    step();
    imem_ack_i   = 1'b0;
    imem_rdata_i = '0;
    chk("idle_ack_ignored", 32'(inst_valid_o), 32'd0);
    wait_req(32'h0040_0000);
    mem_respond(2);
    consume(0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
